// File: rtl/execute_md_if.sv
// execute_md_if -- handshake/bus bundle between the execute stage and the
// iterative multiply/divide unit.
//   master (execute stage): drives md_valid_i, md_op_i, md_rs1_i, md_rs2_i,
//                           md_flush_i; observes ready/busy/valid/result.
//   slave  (md unit)      : the reverse direction.
interface execute_md_if #(
    parameter int WIDTH = 32
);
    logic             md_valid_i;
    logic [2:0]       md_op_i;
    logic [WIDTH-1:0] md_rs1_i;
    logic [WIDTH-1:0] md_rs2_i;
    logic             md_flush_i;
    logic             md_ready_o;
    logic             md_busy_o;
    logic             md_valid_o;
    logic [WIDTH-1:0] md_result_o;

    modport master (
        output md_valid_i, md_op_i, md_rs1_i, md_rs2_i, md_flush_i,
        input  md_ready_o, md_busy_o, md_valid_o, md_result_o
    );

    modport slave (
        input  md_valid_i, md_op_i, md_rs1_i, md_rs2_i, md_flush_i,
        output md_ready_o, md_busy_o, md_valid_o, md_result_o
    );
endinterface

// File: rtl/execute_md_unit.sv
// execute_md_unit -- iterative RV32M multiply/divide unit.
//   clk, rst : clock, asynchronous active-high reset
//   md       : execute_md_if.slave
//              request  : md_valid_i, md_op_i (funct3), md_rs1_i, md_rs2_i
//              control  : md_flush_i aborts the operation in flight
//              status   : md_ready_o, md_busy_o
//              response : md_valid_o (one-cycle strobe), md_result_o (held)
// Multiplies by shift-add (LSB first) and divides by restoring division
// (MSB first) on operand magnitudes, one step per cycle for WIDTH cycles,
// then applies the recorded result sign.
module execute_md_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    execute_md_if.slave  md
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic en, input logic [WIDTH-1:0] v);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic en, input logic [2*WIDTH-1:0] v);
        return en ? (~v + 1'b1) : v;
    endfunction

    state_t             r_state, w_state_nx;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic               r_neg;
    logic [WIDTH-1:0]   r_b;       // divisor / multiplicand magnitude
    logic [2*WIDTH-1:0] r_acc;     // mul: {partial product, multiplier}; div: low half = dividend/quotient
    logic [WIDTH:0]     r_rem;     // partial remainder
    logic [WIDTH-1:0]   r_result;

    logic w_ready, w_accept, w_last;

    // ---------------- accept-time operand decode ----------------
    logic             w_a_neg, w_b_neg, w_neg_flag, w_fast;
    logic [WIDTH-1:0] w_a_abs, w_b_abs, w_fast_res;
    logic             w_div_zero, w_ovf;

    always_comb begin
        w_a_neg = md.md_rs1_i[WIDTH-1] &&
                  (md.md_op_i == OP_MULH || md.md_op_i == OP_MULHSU ||
                   md.md_op_i == OP_DIV  || md.md_op_i == OP_REM);
        w_b_neg = md.md_rs2_i[WIDTH-1] &&
                  (md.md_op_i == OP_MULH || md.md_op_i == OP_DIV || md.md_op_i == OP_REM);
        w_a_abs = neg_w(w_a_neg, md.md_rs1_i);
        w_b_abs = neg_w(w_b_neg, md.md_rs2_i);
        // Remainder takes the dividend's sign; everything else the XOR.
        w_neg_flag = (md.md_op_i == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

        w_div_zero = md.md_op_i[2] && (md.md_rs2_i == '0);
        w_ovf      = (md.md_op_i == OP_DIV || md.md_op_i == OP_REM) &&
                     (md.md_rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (md.md_rs2_i == '1);
        w_fast     = w_div_zero || w_ovf;
        // op[1] distinguishes REM/REMU from DIV/DIVU.
        if (w_div_zero)
            w_fast_res = md.md_op_i[1] ? md.md_rs1_i : '1;
        else
            w_fast_res = md.md_op_i[1] ? '0 : md.md_rs1_i;
    end

    // ---------------- iteration step ----------------
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nx, w_prod;
    logic [WIDTH:0]     w_shift, w_rem_nx;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_quo_nx, w_calc_res;

    always_comb begin
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_acc_nx = {w_sum, r_acc[WIDTH-1:1]};

        w_shift  = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
        w_diff   = {1'b0, w_shift} - {2'b00, r_b};
        w_qbit   = ~w_diff[WIDTH+1];          // no borrow: divisor fits
        w_rem_nx = w_qbit ? w_diff[WIDTH:0] : w_shift;
        w_quo_nx = {r_acc[WIDTH-2:0], w_qbit};

        w_prod = neg_2w(r_neg, w_acc_nx);
        case (r_op)
            OP_MUL:         w_calc_res = w_prod[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         w_calc_res = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: w_calc_res = neg_w(r_neg, w_quo_nx);
            default:        w_calc_res = neg_w(r_neg, w_rem_nx[WIDTH-1:0]);
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        w_ready    = (r_state == S_IDLE || r_state == S_DONE) && !md.md_flush_i;
        w_accept   = md.md_valid_i && w_ready;
        w_last     = (r_cnt == '0);
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nx = w_fast ? S_DONE : S_CALC;
            S_CALC: begin
                if (md.md_flush_i) w_state_nx = S_IDLE;
                else if (w_last)   w_state_nx = S_DONE;
            end
            S_DONE: begin
                if (w_accept) w_state_nx = w_fast ? S_DONE : S_CALC;
                else          w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign md.md_ready_o  = w_ready;
    assign md.md_busy_o   = (r_state == S_CALC);
    assign md.md_valid_o  = (r_state == S_DONE) && !md.md_flush_i;
    assign md.md_result_o = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_cnt <= CW'(WIDTH-1);
                if (w_fast) r_result <= w_fast_res;
            end else if (r_state == S_CALC && !md.md_flush_i) begin
                if (w_last) r_result <= w_calc_res;
                else        r_cnt    <= r_cnt - 1'b1;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= md.md_op_i;
            r_neg <= w_neg_flag;
            r_b   <= w_b_abs;
            r_acc <= {{WIDTH{1'b0}}, w_a_abs};
            r_rem <= '0;
        end else if (r_state == S_CALC) begin
            if (r_op[2]) begin
                r_acc[WIDTH-1:0] <= w_quo_nx;
                r_rem            <= w_rem_nx;
            end else begin
                r_acc <= w_acc_nx;
            end
        end
    end
endmodule

// File: tb/tb_execute_md_unit.sv
module tb_execute_md_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    execute_md_if #(.WIDTH(32)) mif ();
    execute_md_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .md(mif.slave));

    // Reference model: RV32M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        logic [63:0] ua64 = {32'b0, a};
        logic [63:0] ub64 = {32'b0, b};
        logic [63:0] p;
        case (op)
            3'd0: begin p = ua64 * ub64; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub64); return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % longint'(ub64); return p[31:0];
            end
        endcase
    endfunction

    // Issue one operation from idle/DONE and wait (bounded) for the strobe.
    // lat = number of rising edges from the accepting edge to the strobe.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        mif.md_valid_i = 1'b1;
        mif.md_op_i    = op;
        mif.md_rs1_i   = a;
        mif.md_rs2_i   = b;
        @(posedge clk); #1;
        mif.md_valid_i = 1'b0;
        mif.md_rs1_i   = $urandom;
        mif.md_rs2_i   = $urandom;
        lat = 1;
        busy_cnt = 0;
        while (!mif.md_valid_o && lat < 100) begin
            if (mif.md_busy_o) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = mif.md_result_o;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (mif.md_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", mif.md_ready_o); end
        checks++; if (mif.md_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mif.md_busy_o); end
        checks++; if (mif.md_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mif.md_valid_o); end
        checks++; if (mif.md_result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", mif.md_result_o); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (mif.md_ready_o !== 1'b1 || mif.md_busy_o !== 1'b0 || mif.md_valid_o !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle got r%b b%b v%b want r1 b0 v0", mif.md_ready_o, mif.md_busy_o, mif.md_valid_o); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                   32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                   32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
        int          lats [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat, bc;
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bc);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL dir%0d_result op%0d got %h want %h", i, ops[i], res, exps[i]); end
            checks++; if (lat !== lats[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, lats[i]); end
            if (i == 0) begin
                checks++; if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", bc); end
            end
            @(posedge clk); #1;
            checks++; if (mif.md_valid_o !== 1'b0 || mif.md_result_o !== exps[i])
                begin errors++; $display("FAIL dir%0d_strobe_once got v%b %h want v0 %h", i, mif.md_valid_o, mif.md_result_o, exps[i]); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev, res;
        int          strobes, lat, bc;
        prev = mif.md_result_o;
        @(negedge clk);
        mif.md_valid_i = 1'b1; mif.md_op_i = 3'd5; mif.md_rs1_i = 32'd1000; mif.md_rs2_i = 32'd3;
        @(posedge clk); #1;
        mif.md_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        mif.md_flush_i = 1'b1;
        #1;
        checks++; if (mif.md_ready_o !== 1'b0 || mif.md_busy_o !== 1'b1)
            begin errors++; $display("FAIL flush_calc_status got r%b b%b want r0 b1", mif.md_ready_o, mif.md_busy_o); end
        @(posedge clk); #1;
        mif.md_flush_i = 1'b0;
        #1;
        checks++; if (mif.md_ready_o !== 1'b1 || mif.md_busy_o !== 1'b0)
            begin errors++; $display("FAIL flush_idle got r%b b%b want r1 b0", mif.md_ready_o, mif.md_busy_o); end
        checks++; if (mif.md_result_o !== prev) begin errors++; $display("FAIL flush_result_held got %h want %h", mif.md_result_o, prev); end
        strobes = 0;
        repeat (40) begin @(posedge clk); #1; if (mif.md_valid_o) strobes++; end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL flush_no_strobe got %0d want 0", strobes); end
        run_op(3'd0, 32'd3, 32'd5, res, lat, bc);
        checks++; if (res !== 32'd15) begin errors++; $display("FAIL after_flush_mul got %h want f", res); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL after_flush_latency got %0d want 33", lat); end
        // Flush during the DONE cycle suppresses the strobe.
        run_op(3'd7, 32'd50, 32'd8, res, lat, bc);
        mif.md_flush_i = 1'b1;
        #1;
        checks++; if (mif.md_valid_o !== 1'b0) begin errors++; $display("FAIL flush_done_gate got %b want 0", mif.md_valid_o); end
        @(posedge clk); #1;
        mif.md_flush_i = 1'b0;
        #1;
        checks++; if (mif.md_ready_o !== 1'b1 || mif.md_valid_o !== 1'b0 || mif.md_busy_o !== 1'b0)
            begin errors++; $display("FAIL flush_done_idle got r%b v%b b%b want r1 v0 b0", mif.md_ready_o, mif.md_valid_o, mif.md_busy_o); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat, bc;
        @(negedge clk);
        mif.md_valid_i = 1'b1; mif.md_op_i = 3'd4; mif.md_rs1_i = 32'd12345; mif.md_rs2_i = 32'd7;
        @(posedge clk); #1;
        mif.md_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mif.md_ready_o !== 1'b1 || mif.md_busy_o !== 1'b0 || mif.md_valid_o !== 1'b0 || mif.md_result_o !== 32'h0)
            begin errors++; $display("FAIL async_reset got r%b b%b v%b %h want r1 b0 v0 0", mif.md_ready_o, mif.md_busy_o, mif.md_valid_o, mif.md_result_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (mif.md_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", mif.md_ready_o); end
        run_op(3'd7, 32'd100, 32'd7, res, lat, bc);
        checks++; if (res !== 32'd2 || lat !== 33) begin errors++; $display("FAIL post_reset_op got %h lat %0d want 2 lat 33", res, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat, bc, gap;
        run_op(3'd0, 32'd6, 32'd7, res, lat, bc);
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL b2b_first got %h want 2a", res); end
        // Still in the DONE cycle: issue the next operation now.
        mif.md_valid_i = 1'b1; mif.md_op_i = 3'd5; mif.md_rs1_i = 32'd1000; mif.md_rs2_i = 32'd10;
        @(posedge clk); #1;
        mif.md_valid_i = 1'b0;
        checks++; if (mif.md_busy_o !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b want 1", mif.md_busy_o); end
        gap = 1;
        while (!mif.md_valid_o && gap < 100) begin @(posedge clk); #1; gap++; end
        checks++; if (gap !== 33) begin errors++; $display("FAIL b2b_gap got %0d want 33", gap); end
        checks++; if (mif.md_result_o !== 32'd100) begin errors++; $display("FAIL b2b_second got %h want 64", mif.md_result_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp_res;
        int          lat, bc, exp_lat;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'd1;
                3: b = 32'($urandom_range(1, 255));
                default: ;
            endcase
            exp_res = ref_md(op, a, b);
            exp_lat = (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
            run_op(op, a, b, res, lat, bc);
            checks++; if (res !== exp_res) begin errors++; $display("FAIL rand%0d op%0d a=%h b=%h got %h want %h", n, op, a, b, res, exp_res); end
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, exp_lat); end
            @(posedge clk); #1;
            checks++; if (mif.md_valid_o !== 1'b0 || mif.md_ready_o !== 1'b1 || mif.md_result_o !== exp_res)
                begin errors++; $display("FAIL rand%0d_after got v%b r%b %h want v0 r1 %h", n, mif.md_valid_o, mif.md_ready_o, mif.md_result_o, exp_res); end
        end
    endtask

    initial begin
        mif.md_valid_i = 1'b0;
        mif.md_op_i    = 3'd0;
        mif.md_rs1_i   = 32'h0;
        mif.md_rs2_i   = 32'h0;
        mif.md_flush_i = 1'b0;
        test_reset();
        test_directed();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_md_unit.md
# execute_md_unit

Iterative multiply/divide unit for the execute stage, covering the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It is parametrised in data width and sits beside the single-cycle ALU. The execute stage issues an operation through a valid/ready handshake and stalls the pipeline until the one-cycle result strobe. A flush input aborts an in-flight operation, for example on a branch mispredict fix.

## Interface
- WIDTH, 32, operand/result width in bits (even, ≥ 8)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- md_valid_i  in  1  operation request
- md_op_i  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- md_rs1_i  in  WIDTH  operand A / dividend
- md_rs2_i  in  WIDTH  operand B / divisor
- md_flush_i  in  1  abort current operation
- md_ready_o  out  1  unit can accept a request this cycle
- md_busy_o  out  1  operation in flight; execute stage stalls on it
- md_valid_o  out  1  one-cycle result strobe
- md_result_o  out  WIDTH  result; held until the next result strobe

## Operation
- Three states: IDLE, CALC, DONE.
  - md_ready_o = (state == IDLE || state == DONE) && !md_flush_i.
  - md_busy_o = (state == CALC).
- Accept condition: md_valid_i && md_ready_o.
- On accept, the unit latches the op and the operand magnitudes, then forms signed operands:
  - Operands are absolute values for signed ops: rs1 is signed for MULH, MULHSU, DIV and REM; rs2 is signed for MULH, DIV and REM.
  - The unit records the result-sign flag:
    - MUL/MULH/MULHSU/DIV: sign(A) XOR sign(B).
    - REM: sign(A).
  - The step counter loads WIDTH-1.
- Fast paths on accept go straight to DONE:
  - Divisor zero: DIV/DIVU give all-ones; REM/REMU give rs1 unchanged.
  - Signed overflow (rs1 = most-negative, rs2 = all-ones): DIV gives rs1; REM gives 0.
- Otherwise the unit moves to CALC.
- CALC performs one step per cycle for exactly WIDTH cycles.
  - Multiply: shift-add into a 2·WIDTH accumulator, one multiplier bit per step, LSB first.
  - Divide: restoring shift-subtract, giving one quotient bit per step, MSB first, with a WIDTH+1-bit partial remainder.
  - The counter decrements each step. On the step with counter == 0, the unit applies the sign flag to the result by two's complement (over 2·WIDTH for products), registers the result and enters DONE.
- Result selection:
  - MUL: low WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high WIDTH bits of the signed-corrected product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- DONE lasts one cycle: md_valid_o = 1.
  - It returns to IDLE unless a new request is accepted in the same cycle, in which case it goes to CALC or DONE (fast path) directly.
- Flush:
  - md_flush_i in CALC or DONE forces IDLE on the next edge.
  - md_valid_o is gated low in any cycle where md_flush_i = 1.
  - Flush takes priority over accept in the same cycle (ready is masked).
  - md_result_o keeps its previous value.

## Timing
- Reset (async, immediate): state IDLE, md_ready_o 1, md_busy_o 0, md_valid_o 0, md_result_o 0, counter 0.
- Reset asserted mid-CALC aborts the operation with no result strobe. The unit is ready in the first cycle after reset is released.
- Normal latency: md_valid_o is high in the cycle following the (WIDTH+1)-th rising edge after the accepting edge (accept edge plus WIDTH CALC edges). For WIDTH = 32, that is edge 33.
- Fast-path latency: md_valid_o is high in the cycle right after the accepting edge.
- Throughput: back-to-back issue is possible; a new op accepted in the DONE cycle starts CALC at the next edge.
- md_result_o changes only on the edge that enters DONE.
- Operand inputs are don't-care after the accepting edge.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), WIDTH = 32 -> md_valid_o high exactly 33 edges after accept; result 0xFFFFFFEB; md_busy_o high for 32 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF, and REM 0x1234 / 0 -> 0x1234, each one edge after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM of the same -> 0, each one edge after accept.
- Flush at CALC cycle 10 -> no md_valid_o; md_ready_o high next cycle; md_result_o unchanged. A following MUL 3 × 5 -> 15 with full latency.
- Async rst pulse mid-CALC -> outputs go to reset values immediately. Back-to-back DIVU issued in the DONE cycle of a prior MUL -> both results strobed, 33 edges apart.
